// File: rtl/hex2ascii_pkg.sv
// hex2ascii_pkg: shared types and constants for the hex-to-ASCII serializer.
//   state_t    - serializer FSM states
//   ASCII_*    - fixed characters emitted by the block
//   OFS_*      - offsets added to nibbles 10..15 for upper/lower case letters
package hex2ascii_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDig  = 2'd1,
    StCr   = 2'd2,
    StLf   = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] OFS_UPPER = 8'h37;
  localparam logic [7:0] OFS_LOWER = 8'h57;

endpackage

// File: rtl/hex2ascii_tx_nib2ascii.sv
// nib2ascii: combinational nibble-to-ASCII-hex-digit converter.
//   i_nib   - 4-bit value to convert
//   i_upper - 1 selects 'A'-'F' for 10..15, 0 selects 'a'-'f'
//   o_char  - ASCII character
module nib2ascii
  import hex2ascii_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_upper,
  output logic [7:0] o_char
);

  logic [7:0] w_ext;

  assign w_ext = {4'b0000, i_nib};

  always_comb begin
    if (i_nib < 4'd10) begin
      o_char = ASCII_0 + w_ext;
    end else begin
      o_char = (i_upper ? OFS_UPPER : OFS_LOWER) + w_ext;
    end
  end

endmodule

// File: rtl/hex2ascii_tx.sv
// hex2ascii_tx: prints a 16-bit word as four ASCII hex characters, MS nibble
// first, optionally followed by CR/LF. Valid/ready on both sides.
//   clk, rst            - clock, asynchronous active-low reset
//   i_in_valid/i_in_data/o_in_ready    - word input handshake
//   o_out_valid/o_out_data/i_out_ready - character output handshake
//   o_busy              - high whenever a word is in flight
module hex2ascii_tx
  import hex2ascii_pkg::*;
#(
  parameter bit UPPER   = 1'b1,
  parameter bit TERM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_in_valid,
  input  logic [15:0] i_in_data,
  output logic        o_in_ready,
  output logic        o_out_valid,
  output logic [7:0]  o_out_data,
  input  logic        i_out_ready,
  output logic        o_busy
);

  state_t      r_state, w_state_d;
  logic [1:0]  r_idx, w_idx_d;
  logic [15:0] r_shadow, w_shadow_d;
  logic        r_out_valid, w_out_valid_d;
  logic [7:0]  r_out_data, w_out_data_d;

  logic        w_xfer;
  logic [1:0]  w_idx_next;
  logic [3:0]  w_nib;
  logic [7:0]  w_char;

  assign w_xfer     = r_out_valid & i_out_ready;
  assign w_idx_next = r_idx + 2'd1;

  // In IDLE the first character comes straight from the incoming word, since
  // the shadow register is only loaded on the same edge; afterwards the
  // converter looks one digit ahead of the one currently on the output.
  always_comb begin
    w_nib = i_in_data[15:12];
    if (r_state != StIdle) begin
      unique case (w_idx_next)
        2'd0: w_nib = r_shadow[15:12];
        2'd1: w_nib = r_shadow[11:8];
        2'd2: w_nib = r_shadow[7:4];
        2'd3: w_nib = r_shadow[3:0];
        default: w_nib = r_shadow[15:12];
      endcase
    end
  end

  nib2ascii u_nib2ascii (
    .i_nib  (w_nib),
    .i_upper(UPPER),
    .o_char (w_char)
  );

  always_comb begin
    w_state_d     = r_state;
    w_idx_d       = r_idx;
    w_shadow_d    = r_shadow;
    w_out_valid_d = r_out_valid;
    w_out_data_d  = r_out_data;
    unique case (r_state)
      StIdle: begin
        if (i_in_valid) begin
          w_shadow_d    = i_in_data;
          w_idx_d       = 2'd0;
          w_state_d     = StDig;
          w_out_data_d  = w_char;
          w_out_valid_d = 1'b1;
        end
      end
      StDig: begin
        if (w_xfer) begin
          if (r_idx != 2'd3) begin
            w_idx_d      = w_idx_next;
            w_out_data_d = w_char;
          end else if (TERM_EN) begin
            w_state_d    = StCr;
            w_out_data_d = ASCII_CR;
          end else begin
            w_state_d     = StIdle;
            w_out_valid_d = 1'b0;
          end
        end
      end
      StCr: begin
        if (w_xfer) begin
          w_state_d    = StLf;
          w_out_data_d = ASCII_LF;
        end
      end
      StLf: begin
        if (w_xfer) begin
          w_state_d     = StIdle;
          w_out_valid_d = 1'b0;
        end
      end
      default: begin
        w_state_d     = StIdle;
        w_out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_idx       <= 2'd0;
      r_shadow    <= 16'h0000;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
    end else begin
      r_state     <= w_state_d;
      r_idx       <= w_idx_d;
      r_shadow    <= w_shadow_d;
      r_out_valid <= w_out_valid_d;
      r_out_data  <= w_out_data_d;
    end
  end

  assign o_in_ready  = (r_state == StIdle);
  assign o_busy      = (r_state != StIdle);
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;

endmodule

// File: doc/hex2ascii_tx.md
# hex2ascii_tx

Serializer that takes a 16-bit value and emits it as four ASCII hex characters, most-significant nibble first, with an optional CR/LF terminator. It sits between the datapath and the UART transmitter on the debug/console path. It is the transmit-side counterpart of the ASCII-to-hex capture logic. Valid/ready handshakes are used on both sides, so the UART can stall it freely.

## Interface
- UPPER, 1, 1 selects 'A'–'F' (0x41–0x46) for digits 10–15; 0 selects 'a'–'f' (0x61–0x66).
- TERM_EN, 1, 1 appends 0x0D then 0x0A after the fourth digit; 0 sends digits only.
- clk  in  1  system clock (100 MHz); all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_data is valid.
- in_data  in  16  value to print; nibble [15:12] is sent first.
- in_ready  out  1  block can accept a word. High only in IDLE.
- out_valid  out  1  out_data holds a character for the UART.
- out_data  out  8  ASCII character.
- out_ready  in  1  UART accepts the character this cycle.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, DIG, CR, LF. A 2-bit digit index (0..3) and a 16-bit shadow register hold the word being sent.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - capture in_data into the shadow register;
  - set index=0 and go to DIG;
  - load out_data with the character for nibble [15:12];
  - set out_valid=1.
- DIG: a transfer happens when out_valid&&out_ready.
  - On a transfer with index<3: increment index and load the next nibble's character.
  - On a transfer with index==3: go to CR (TERM_EN=1) with out_data=0x0D, or to IDLE with out_valid=0 (TERM_EN=0).
- CR: on transfer, go to LF with out_data=0x0A.
- LF: on transfer, go to IDLE with out_valid=0.
- Nibble-to-character conversion:
  - n<10 → 0x30+n;
  - n≥10 → 0x37+n when UPPER=1, 0x57+n when UPPER=0.
  - Arithmetic is 8-bit, zero-extend n. No invalid-nibble case exists.
- Backpressure: while out_valid&&!out_ready, out_data, out_valid, state and index hold unchanged.
- in_valid outside IDLE is ignored. The shadow register is not overwritten.
- in_data is sampled only at the accept edge. Later changes have no effect on the word being sent.
- Reset mid-word: the current word is dropped with no partial completion. The block returns to IDLE; the next word starts at its nibble [15:12].

## Timing
- Reset values: state=IDLE, out_valid=0, out_data=0x00, index=0, shadow=0x0000, busy=0, in_ready=1.
- out_valid and out_data are registered. in_ready and busy are decoded from the state register, with no combinational path from in_valid or out_ready.
- Latency: word accepted at edge k → first character valid in cycle k+1.
- Throughput with out_ready held at 1: one character per cycle.
  - Word length is 6 cycles with TERM_EN=1, 4 cycles with TERM_EN=0.
  - One IDLE bubble cycle follows each word. A new word is accepted no earlier than one edge after the final transfer.
- Simultaneous reset deassertion and in_valid: the first rising edge after deassertion may accept.

## Structure
- Package hex2ascii_pkg holds:
  - state encoding (IDLE, DIG, CR, LF);
  - ASCII_0=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A;
  - offsets 8'h37 and 8'h57.
- One combinational sub-module, nib2ascii: 4-bit nibble and UPPER in, 8-bit character out. It is instantiated once and fed by an index-selected nibble of the shadow register.

## Test plan
- UPPER=1, TERM_EN=1, in_data=0x12AF, out_ready=1 → out_data 0x31,0x32,0x41,0x46,0x0D,0x0A on consecutive cycles starting one cycle after accept; busy drops after the 0x0A transfer.
- UPPER=0, TERM_EN=0, in_data=0xBEEF → 0x62,0x65,0x65,0x66. No CR/LF is sent, and the block returns to IDLE.
- Backpressure: word 0x0907 with out_ready=0 for 3 cycles while the second character is valid → 0x39 held stable for all 3 cycles, then sequence 0x30,0x39,0x30,0x37 completes with no loss or duplication.
- Busy input: hold in_valid=1 with 0x1111, then 0x2222, throughout → in_ready low while busy, 0x2222 ignored mid-word, exactly one IDLE bubble, then the next accept takes whatever in_data is present.
- Reset mid-word: assert rst during the third character of 0xABCD → out_valid=0 and in_ready=1 immediately. After release, word 0x0000 yields 0x30×4 (+0x0D,0x0A).
- Exhaustive nibbles: words 0x0123, 0x4567, 0x89AB, 0xCDEF under both UPPER settings → every character matches the conversion rule.
